// File: rtl/sccb_init_sequencer.sv
// Walks the camera configuration ROM and issues one SCCB register write per entry through a
// req/ack handshake. It also decodes the timed-delay (FFF0) and end-of-table (FFFF) markers.
module sccb_init_sequencer #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned DELAY_MS    = 10,
    parameter int unsigned ROM_AW      = 8,
    parameter int unsigned ACK_TIMEOUT = 65535,
    parameter logic [7:0]  DEV_ID      = 8'h42
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              wr_req_o,
    input  logic              wr_ack_i,
    output logic [7:0]        wr_dev_id_o,
    output logic [7:0]        wr_reg_addr_o,
    output logic [7:0]        wr_reg_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ROM_AW-1:0] wr_count_o
);

    localparam int unsigned    DelayCycles = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam logic [31:0]    DelayLoad   = 32'(DelayCycles - 1);
    localparam logic [31:0]    TmoLast     = 32'(ACK_TIMEOUT - 1);
    localparam logic [ROM_AW-1:0] AddrMax  = {ROM_AW{1'b1}};
    localparam logic [15:0]    MarkEnd     = 16'hFFFF;
    localparam logic [15:0]    MarkDelay   = 16'hFFF0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StDelay,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_AW-1:0] wr_count_q, wr_count_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic              wr_req_q, wr_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       delay_q, delay_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              advance;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rom_addr_q <= '0;
            wr_count_q <= '0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            wr_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            delay_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            wr_count_q <= wr_count_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            wr_req_q   <= wr_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            delay_q    <= delay_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        wr_count_d = wr_count_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        wr_req_d   = wr_req_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        delay_d    = delay_q;
        tmo_d      = tmo_q;
        advance    = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    rom_addr_d = '0;
                    wr_count_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StFetch;
                end
            end
            // Covers the one-cycle registered ROM read latency.
            StFetch: state_d = StDecode;
            StDecode: begin
                if (rom_data_i == MarkEnd) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (rom_data_i == MarkDelay) begin
                    delay_d = DelayLoad;
                    state_d = StDelay;
                end else begin
                    reg_addr_d = rom_data_i[15:8];
                    reg_data_d = rom_data_i[7:0];
                    wr_req_d   = 1'b1;
                    tmo_d      = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (wr_ack_i) begin
                    wr_req_d = 1'b0;
                    if (wr_count_q != AddrMax) begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                    advance = 1'b1;
                end else if (tmo_q == TmoLast) begin
                    wr_req_d = 1'b0;
                    error_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StError;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StDelay: begin
                if (delay_q == '0) begin
                    advance = 1'b1;
                end else begin
                    delay_d = delay_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The last ROM slot ends the run rather than wrapping to address 0.
        if (advance) begin
            if (rom_addr_q == AddrMax) begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StDone;
            end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d    = StFetch;
            end
        end
    end

    assign rom_addr_o    = rom_addr_q;
    assign wr_req_o      = wr_req_q;
    assign wr_dev_id_o   = DEV_ID;
    assign wr_reg_addr_o = reg_addr_q;
    assign wr_reg_data_o = reg_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign wr_count_o    = wr_count_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: an 8-bit-address instance with a short delay and
// timeout, plus a 2-bit-address instance for the no-wrap and count-saturation cases.
module tb_sccb_init_sequencer;

    localparam int unsigned DelayN = 200;  // 100 kHz * 2 ms
    localparam int unsigned Tmo    = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A
    logic        start_a = 1'b0;
    logic [7:0]  addr_a, dev_a, ra_a, rd_a, cnt_a;
    logic [15:0] rdata_a;
    logic        req_a, ack_a, busy_a, done_a, err_a;
    logic        m_ack_a = 1'b0, stray_ack_a = 1'b0;
    logic [15:0] rom_a [256];
    assign ack_a = m_ack_a | stray_ack_a;
    always @(posedge clk) rdata_a <= rom_a[addr_a];

    sccb_init_sequencer #(
        .CLK_FREQ_HZ(100_000), .DELAY_MS(2), .ROM_AW(8), .ACK_TIMEOUT(Tmo), .DEV_ID(8'h42)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .rom_addr_o(addr_a),
        .rom_data_i(rdata_a), .wr_req_o(req_a), .wr_ack_i(ack_a), .wr_dev_id_o(dev_a),
        .wr_reg_addr_o(ra_a), .wr_reg_data_o(rd_a), .busy_o(busy_a), .done_o(done_a),
        .error_o(err_a), .wr_count_o(cnt_a)
    );

    // Instance B
    logic        start_b = 1'b0;
    logic [1:0]  addr_b, cnt_b;
    logic [7:0]  dev_b, ra_b, rd_b;
    logic [15:0] rdata_b;
    logic        req_b, busy_b, done_b, err_b;
    logic        m_ack_b = 1'b0;
    logic [15:0] rom_b [4];
    always @(posedge clk) rdata_b <= rom_b[addr_b];

    sccb_init_sequencer #(
        .CLK_FREQ_HZ(100_000), .DELAY_MS(1), .ROM_AW(2), .ACK_TIMEOUT(50), .DEV_ID(8'h42)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .rom_addr_o(addr_b),
        .rom_data_i(rdata_b), .wr_req_o(req_b), .wr_ack_i(m_ack_b), .wr_dev_id_o(dev_b),
        .wr_reg_addr_o(ra_b), .wr_reg_data_o(rd_b), .busy_o(busy_b), .done_o(done_b),
        .error_o(err_b), .wr_count_o(cnt_b)
    );

    // Master model A: acks ack_dly_a cycles after req rises and logs each write.
    bit          ack_en_a = 1'b1;
    int          ack_dly_a = 5;
    int          age_a = 0;
    int          cyc = 0;
    int          dev_bad = 0;
    logic [15:0] log_a[$];
    int          rise_a[$];
    int          ackc_a[$];

    initial forever begin
        @(posedge clk); #1;
        cyc++;
        m_ack_a = 1'b0;
        if (req_a) begin
            if (age_a == 0) begin
                rise_a.push_back(cyc);
                if (dev_a !== 8'h42) dev_bad++;
            end
            age_a++;
            if (ack_en_a && age_a == ack_dly_a) begin
                m_ack_a = 1'b1;
                log_a.push_back({ra_a, rd_a});
                ackc_a.push_back(cyc);
            end
        end else begin
            age_a = 0;
        end
    end

    int          age_b = 0;
    logic [15:0] log_b[$];

    initial forever begin
        @(posedge clk); #1;
        m_ack_b = 1'b0;
        if (req_b) begin
            age_b++;
            if (age_b == 2) begin
                m_ack_b = 1'b1;
                log_b.push_back({ra_b, rd_b});
            end
        end else begin
            age_b = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_a();
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
        log_a.delete(); rise_a.delete(); ackc_a.delete();
    endtask

    task automatic pulse_a();
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy_a) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;
        fill_a();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({addr_a, req_a, busy_a, done_a, err_a, cnt_a, ra_a, rd_a} !== '0) begin
            n_fail++; $display("FAIL reset_a: got %h want 0",
                {addr_a, req_a, busy_a, done_a, err_a, cnt_a, ra_a, rd_a});
        end
        n_tests++;
        if (dev_a !== 8'h42) begin n_fail++; $display("FAIL reset_dev: got %h want 42", dev_a); end
        n_tests++;
        if ({addr_b, req_b, busy_b, done_b, err_b, cnt_b, ra_b, rd_b, dev_b} !== {28'h0, 8'h42})
        begin
            n_fail++; $display("FAIL reset_b: got %h want 42",
                {addr_b, req_b, busy_b, done_b, err_b, cnt_b, ra_b, rd_b, dev_b});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int gap = 0;
        bit ok = 1'b0;
        bit ok2;
        fill_a();
        rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1214; rom_a[3] = 16'hFFFF;
        ack_dly_a = 5; ack_en_a = 1'b1;
        pulse_a();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (addr_a == 8'd1) gap++;
            if (addr_a == 8'd2) begin ok = 1'b1; break; end
        end
        wait_idle_a(2000, ok2);
        n_tests++;
        if (!ok || gap < int'(DelayN) - 3 || gap > int'(DelayN) + 3) begin
            n_fail++; $display("FAIL basic_delay_gap: got %0d (ok=%0d) want %0d+-3", gap, ok, DelayN);
        end
        n_tests++;
        if (!ok2) begin n_fail++; $display("FAIL basic_finish: busy still high, want low"); end
        n_tests++;
        if (log_a.size() != 2) begin
            n_fail++; $display("FAIL basic_nwrites: got %0d want 2", log_a.size());
        end else if (log_a[0] !== 16'h1280 || log_a[1] !== 16'h1214) begin
            n_fail++; $display("FAIL basic_writes: got %h,%h want 1280,1214", log_a[0], log_a[1]);
        end
        n_tests++;
        if ({done_a, err_a, cnt_a} !== {1'b1, 1'b0, 8'd2}) begin
            n_fail++; $display("FAIL basic_status: got done=%b err=%b cnt=%0d want 1,0,2",
                done_a, err_a, cnt_a);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fill_a();
        rom_a[0] = 16'h1101; rom_a[1] = 16'h1202; rom_a[2] = 16'h1303;
        pulse_a();
        wait_idle_a(500, ok);
        n_tests++;
        if (!ok || rise_a.size() != 3 || ackc_a.size() != 3) begin
            n_fail++; $display("FAIL b2b_count: got %0d rises %0d acks (ok=%0d) want 3,3",
                rise_a.size(), ackc_a.size(), ok);
        end else begin
            n_tests++;
            if (rise_a[1] - ackc_a[0] != 3 || rise_a[2] - ackc_a[1] != 3) begin
                n_fail++; $display("FAIL b2b_gap: got %0d,%0d want 3,3",
                    rise_a[1] - ackc_a[0], rise_a[2] - ackc_a[1]);
            end
        end
    endtask

    task automatic test_full_table();
        logic [15:0] exp_q[$];
        int bad = 0;
        bit ok;
        fill_a();
        rom_a[0] = 16'h1280;
        rom_a[1] = 16'hFFF0;
        exp_q.push_back(16'h1280);
        for (int i = 2; i < 75; i++) begin
            rom_a[i] = {8'(8'h10 + i), 8'(i * 3)};
            exp_q.push_back(rom_a[i]);
        end
        rom_a[75] = 16'hFFFF;
        dev_bad = 0;
        pulse_a();
        wait_idle_a(5000, ok);
        n_tests++;
        if (!ok || log_a.size() != 74) begin
            n_fail++; $display("FAIL full_nwrites: got %0d (ok=%0d) want 74", log_a.size(), ok);
        end else begin
            for (int k = 0; k < 74; k++) if (log_a[k] !== exp_q[k]) bad++;
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL full_payload: got %0d bad want 0", bad); end
        end
        n_tests++;
        if (dev_bad != 0) begin n_fail++; $display("FAIL full_dev_id: got %0d bad want 0", dev_bad); end
        n_tests++;
        if ({done_a, err_a, cnt_a} !== {1'b1, 1'b0, 8'd74}) begin
            n_fail++; $display("FAIL full_status: got done=%b err=%b cnt=%0d want 1,0,74",
                done_a, err_a, cnt_a);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen = 1'b0;
        bit fell = 1'b0;
        fill_a();
        rom_a[0] = 16'h1234;
        ack_en_a = 1'b0;
        pulse_a();
        for (int i = 0; i < 20; i++) begin
            if (req_a) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 500 && seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (!req_a) begin fell = 1'b1; break; end
        end
        n_tests++;
        if (!fell || n != int'(Tmo)) begin
            n_fail++; $display("FAIL tmo_len: got %0d (seen=%0d fell=%0d) want %0d", n, seen, fell, Tmo);
        end
        n_tests++;
        if ({err_a, done_a, busy_a, req_a, cnt_a, addr_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0})
        begin
            n_fail++; $display("FAIL tmo_status: got err=%b done=%b busy=%b req=%b cnt=%0d addr=%0d",
                err_a, done_a, busy_a, req_a, cnt_a, addr_a);
        end
        ack_en_a = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_no_wrap();
        bit ok = 1'b0;
        rom_b[0] = 16'h0101; rom_b[1] = 16'h0202; rom_b[2] = 16'h0303; rom_b[3] = 16'h0404;
        log_b.delete();
        @(posedge clk); #1; start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy_b) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (!ok || log_b.size() != 4) begin
            n_fail++; $display("FAIL nowrap_nwrites: got %0d (ok=%0d) want 4", log_b.size(), ok);
        end else if (log_b[0] !== 16'h0101 || log_b[3] !== 16'h0404) begin
            n_fail++; $display("FAIL nowrap_order: got %h..%h want 0101..0404", log_b[0], log_b[3]);
        end
        n_tests++;
        if ({addr_b, done_b, err_b, busy_b} !== {2'd3, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL nowrap_status: got addr=%0d done=%b err=%b busy=%b want 3,1,0,0",
                addr_b, done_b, err_b, busy_b);
        end
        n_tests++;
        if (cnt_b !== 2'd3) begin n_fail++; $display("FAIL nowrap_sat: got %0d want 3", cnt_b); end
    endtask

    task automatic test_ignored();
        bit ok = 1'b0;
        bit ok2;
        fill_a();
        rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1214;
        pulse_a();
        for (int i = 0; i < 100; i++) begin
            if (addr_a == 8'd1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1; start_a = 1'b1; stray_ack_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; stray_ack_a = 1'b0;
        n_tests++;
        if (!ok || addr_a !== 8'd1 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL ignore_inflight: got addr=%0d busy=%b (ok=%0d) want 1,1",
                addr_a, busy_a, ok);
        end
        wait_idle_a(2000, ok2);
        n_tests++;
        if (!ok2 || log_a.size() != 2 || cnt_a !== 8'd2 || done_a !== 1'b1) begin
            n_fail++; $display("FAIL ignore_result: got %0d writes cnt=%0d done=%b want 2,2,1",
                log_a.size(), cnt_a, done_a);
        end else if (log_a[1] !== 16'h1214) begin
            n_fail++; $display("FAIL ignore_payload: got %h want 1214", log_a[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit ok;
        fill_a();
        rom_a[0] = 16'h1280; rom_a[1] = 16'h1214;
        ack_en_a = 1'b0;
        pulse_a();
        for (int i = 0; i < 20; i++) begin
            if (req_a) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (!seen || {req_a, busy_a, addr_a} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL rst_async: got req=%b busy=%b addr=%0d (seen=%0d) want 0,0,0",
                req_a, busy_a, addr_a, seen);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_en_a = 1'b1;
        log_a.delete();
        pulse_a();
        wait_idle_a(500, ok);
        n_tests++;
        if (!ok || log_a.size() != 2) begin
            n_fail++; $display("FAIL rst_restart_n: got %0d (ok=%0d) want 2", log_a.size(), ok);
        end else if (log_a[0] !== 16'h1280 || log_a[1] !== 16'h1214) begin
            n_fail++; $display("FAIL rst_restart: got %h,%h want 1280,1214", log_a[0], log_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full_table();
        test_timeout();
        test_no_wrap();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
